divmod_arbiter: RTL and testbench
=================================

Name: divmod_arbiter

Overview:
- Shares one multi-cycle divmod unit between NREQ independent requesters, e.g. several candidate-testing lanes of the prime generator.
- Grants the divider round-robin and latches the granted client's operands.
- Drives the divider's edge-triggered go and waits for its ready.
- Returns quotient, remainder and error to the owning client with a one-cycle done pulse; a watchdog flags a divider that never completes.

Parameters:
- WIDTH_LOG, 4, log2 of operand width; WIDTH = 1 << WIDTH_LOG.
- NREQ, 4, number of requesters, 2..8; IDXW = 3 bits for the owner index.
- TIMEOUT, 255, maximum WAIT cycles before abort; fits an 8-bit counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-client request level
- a_in  in  NREQ*WIDTH  client dividends, client i at bits [i*WIDTH +: WIDTH]
- b_in  in  NREQ*WIDTH  client divisors, same packing
- done  out  NREQ  one-cycle completion pulse, one-hot to the owner
- res_div  out  WIDTH  quotient, valid while done != 0
- res_mod  out  WIDTH  remainder, valid while done != 0
- res_error  out  1  divide-by-zero or timeout, valid while done != 0
- res_timeout  out  1  set with res_error when the watchdog fired
- res_owner  out  IDXW  index of the completing client
- busy  out  1  high in every state except IDLE
- dv_go  out  1  to divider go
- dv_a  out  WIDTH  to divider a
- dv_b  out  WIDTH  to divider b
- dv_ready  in  1  from divider ready
- dv_error  in  1  from divider error
- dv_div  in  WIDTH  from divider div
- dv_mod  in  WIDTH  from divider mod

Behaviour:
- The divider shares clk and rst with this block. All outputs are registered.
- Reset values: state IDLE, done 0, dv_go 0, dv_a 0, dv_b 0, res_div 0, res_mod 0, res_error 0, res_timeout 0, res_owner 0, busy 0, round-robin pointer 0, watchdog 0.
- IDLE:
  - If dv_ready == 1 and req != 0, grant the first set bit searching from pointer upward with wrap.
  - Latch owner, dv_a and dv_b from that client's slice; set pointer = (owner + 1) mod NREQ; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: dv_go = 1 for exactly this cycle; go to WAIT; clear the watchdog.
- WAIT:
  - dv_go = 0, so the divider always sees a fresh rising edge next time.
  - dv_ready is meaningful from the first WAIT cycle, because the divider updates ready on the edge that samples go.
  - If dv_ready == 1: capture dv_div, dv_mod and dv_error into res_*; res_timeout = 0; go to DONE.
  - Else if watchdog == TIMEOUT: res_error = 1, res_timeout = 1, res_div = 0, res_mod = 0; go to DONE.
  - Else increment the watchdog.
- DONE: done[owner] = 1 for this cycle only; res_* are held; go to IDLE; req is ignored in this cycle.
- Client rule: operands stay stable while req is high until done is seen. The client clears req on the edge that samples done. A req still high in IDLE is a new request.
- Minimum latency: grant edge to done visible is 3 cycles (ISSUE, WAIT, DONE), reached when b == 0 because the divider errors immediately. res_* are held after DONE until the next capture.
- Simultaneous requests:
  - Only one is granted; the others wait with no loss.
  - A client granted last has lowest priority next.
  - Under continuous load all clients are served in rotation within NREQ operations.
- Operands are never re-read from a_in/b_in after the grant; changes after grant do not affect the operation.
- Reset mid-operation: back to IDLE with all outputs at their reset values; no done pulse for the aborted operation; the pointer returns to 0.
- After a timeout the divider is not reset by this block. The next grant still waits for dv_ready == 1.

Test Plan:
- Single request, client 2 (a=100, b=7) -> done = 4'b0100 exactly once; res_div=14, res_mod=2, res_error=0, res_owner=2; dv_go high exactly one cycle.
- Client 0 (a=5, b=0) -> done[0] exactly 3 cycles after the grant edge; res_error=1, res_timeout=0.
- req=4'b1111 held, each client dropping req on its done -> grant order 0,1,2,3; results a_i/b_i correct per owner; no done overlap.
- Client 1 re-requests immediately while client 3 is pending -> order 1,3,1; the rotation pointer is respected.
- Divider model with ready stuck at 0 and TIMEOUT=10 -> done after 11 WAIT cycles; res_error=1, res_timeout=1, res_div=0, res_mod=0.
- rst asserted in WAIT -> next cycle IDLE, busy=0, no done pulse; a subsequent request for 9/3 gives res_div=3, res_mod=0.

Source files
------------

// File: rtl/divmod_arbiter.sv
// divmod_arbiter
//
// Shares one multi-cycle divmod unit between NREQ requesters. A round-robin
// pointer picks the next requesting client. Its operands are latched and the
// divider is started with a single-cycle go pulse. The block then waits for
// the divider's ready. The quotient, remainder and error go back to the
// owning client with a one-cycle, one-hot done pulse. A watchdog ends the
// wait with an error if the divider never completes.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req             per-client request level
//   a_in, b_in      packed client dividends / divisors, client i at [i*WIDTH +: WIDTH]
//   done            one-cycle completion pulse, one-hot to the owner
//   res_div/mod     quotient / remainder, valid while done != 0, held afterwards
//   res_error       divide-by-zero or timeout
//   res_timeout     set together with res_error when the watchdog fired
//   res_owner       index of the completing client
//   busy            high whenever the arbiter is not idle
//   dv_go/a/b       to the divider (go is edge-triggered on the divider side)
//   dv_ready/error/div/mod   from the divider
//
// Every output is registered.

module divmod_arbiter #(
    parameter int WIDTH_LOG = 4,
    parameter int NREQ      = 4,
    parameter int TIMEOUT   = 255,
    localparam int WIDTH    = 1 << WIDTH_LOG,
    localparam int IDXW     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      res_div,
    output logic [WIDTH-1:0]      res_mod,
    output logic                  res_error,
    output logic                  res_timeout,
    output logic [IDXW-1:0]       res_owner,
    output logic                  busy,
    output logic                  dv_go,
    output logic [WIDTH-1:0]      dv_a,
    output logic [WIDTH-1:0]      dv_b,
    input  logic                  dv_ready,
    input  logic                  dv_error,
    input  logic [WIDTH-1:0]      dv_div,
    input  logic [WIDTH-1:0]      dv_mod
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NREQ - 1);
    localparam logic [7:0]      TIMEOUT_W = 8'(TIMEOUT);

    // Round-robin pick: the first set request bit at or above the pointer,
    // wrapping around. Rotating {r, r} right by the pointer puts the search
    // start at bit 0, so the loop only needs constant indices.
    function automatic logic [IDXW-1:0] rr_pick(
        input logic [NREQ-1:0] r,
        input logic [IDXW-1:0] p
    );
        logic [2*NREQ-1:0] rot;
        logic              found;
        int                sum;
        rr_pick = p;
        found   = 1'b0;
        rot     = {r, r} >> p;
        for (int i = 0; i < NREQ; i++) begin
            sum = int'(p) + i;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end else begin
                sum = sum;
            end
            if (!found && rot[i]) begin
                rr_pick = IDXW'(sum);
                found   = 1'b1;
            end else begin
                found = found;
            end
        end
    endfunction

    // One-hot decode of a client index onto the done vector.
    function automatic logic [NREQ-1:0] owner_onehot(input logic [IDXW-1:0] idx);
        for (int i = 0; i < NREQ; i++) begin
            owner_onehot[i] = (idx == IDXW'(i));
        end
    endfunction

    // Registered state
    state_t            state_r;
    logic [IDXW-1:0]   ptr_r;
    logic [IDXW-1:0]   owner_r;
    logic [7:0]        wdog_r;
    logic [NREQ-1:0]   done_r;
    logic [WIDTH-1:0]  res_div_r;
    logic [WIDTH-1:0]  res_mod_r;
    logic              res_error_r;
    logic              res_timeout_r;
    logic [IDXW-1:0]   res_owner_r;
    logic              busy_r;
    logic              dv_go_r;
    logic [WIDTH-1:0]  dv_a_r;
    logic [WIDTH-1:0]  dv_b_r;

    // Next values
    state_t            state_s;
    logic [IDXW-1:0]   ptr_s;
    logic [IDXW-1:0]   owner_s;
    logic [7:0]        wdog_s;
    logic [NREQ-1:0]   done_s;
    logic [WIDTH-1:0]  res_div_s;
    logic [WIDTH-1:0]  res_mod_s;
    logic              res_error_s;
    logic              res_timeout_s;
    logic [IDXW-1:0]   res_owner_s;
    logic              busy_s;
    logic              dv_go_s;
    logic [WIDTH-1:0]  dv_a_s;
    logic [WIDTH-1:0]  dv_b_s;

    logic [IDXW-1:0]   grant_s;
    logic              grant_ok_s;
    logic              wd_hit_s;

    // A grant needs a pending request and an idle divider. The divider may
    // still be busy after a watchdog abort, so ready is checked here too.
    assign grant_s    = rr_pick(req, ptr_r);
    assign grant_ok_s = dv_ready && (req != {NREQ{1'b0}});
    assign wd_hit_s   = (wdog_r == TIMEOUT_W);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_ok_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (dv_ready || wd_hit_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of all registered outputs. The outputs are
    // computed from the current state so that go and done are high during
    // ISSUE and DONE respectively.
    always_comb begin
        ptr_s         = ptr_r;
        owner_s       = owner_r;
        wdog_s        = wdog_r;
        done_s        = {NREQ{1'b0}};
        res_div_s     = res_div_r;
        res_mod_s     = res_mod_r;
        res_error_s   = res_error_r;
        res_timeout_s = res_timeout_r;
        res_owner_s   = res_owner_r;
        dv_go_s       = 1'b0;
        dv_a_s        = dv_a_r;
        dv_b_s        = dv_b_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_ok_s) begin
                    // Operands are taken once here and never re-read.
                    owner_s = grant_s;
                    dv_a_s  = a_in[int'(grant_s)*WIDTH +: WIDTH];
                    dv_b_s  = b_in[int'(grant_s)*WIDTH +: WIDTH];
                    dv_go_s = 1'b1;
                    if (grant_s == LAST_IDX) begin
                        ptr_s = {IDXW{1'b0}};
                    end else begin
                        ptr_s = grant_s + {{(IDXW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    owner_s = owner_r;
                end
            end
            ST_ISSUE: begin
                wdog_s = 8'd0;
            end
            ST_WAIT: begin
                if (dv_ready) begin
                    res_div_s     = dv_div;
                    res_mod_s     = dv_mod;
                    res_error_s   = dv_error;
                    res_timeout_s = 1'b0;
                    res_owner_s   = owner_r;
                    done_s        = owner_onehot(owner_r);
                end else if (wd_hit_s) begin
                    res_div_s     = {WIDTH{1'b0}};
                    res_mod_s     = {WIDTH{1'b0}};
                    res_error_s   = 1'b1;
                    res_timeout_s = 1'b1;
                    res_owner_s   = owner_r;
                    done_s        = owner_onehot(owner_r);
                end else begin
                    wdog_s = wdog_r + 8'd1;
                end
            end
            ST_DONE: begin
                done_s = {NREQ{1'b0}};
            end
            default: begin
                done_s = {NREQ{1'b0}};
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r         <= {IDXW{1'b0}};
            owner_r       <= {IDXW{1'b0}};
            wdog_r        <= 8'd0;
            done_r        <= {NREQ{1'b0}};
            res_div_r     <= {WIDTH{1'b0}};
            res_mod_r     <= {WIDTH{1'b0}};
            res_error_r   <= 1'b0;
            res_timeout_r <= 1'b0;
            res_owner_r   <= {IDXW{1'b0}};
            busy_r        <= 1'b0;
            dv_go_r       <= 1'b0;
            dv_a_r        <= {WIDTH{1'b0}};
            dv_b_r        <= {WIDTH{1'b0}};
        end else begin
            ptr_r         <= ptr_s;
            owner_r       <= owner_s;
            wdog_r        <= wdog_s;
            done_r        <= done_s;
            res_div_r     <= res_div_s;
            res_mod_r     <= res_mod_s;
            res_error_r   <= res_error_s;
            res_timeout_r <= res_timeout_s;
            res_owner_r   <= res_owner_s;
            busy_r        <= busy_s;
            dv_go_r       <= dv_go_s;
            dv_a_r        <= dv_a_s;
            dv_b_r        <= dv_b_s;
        end
    end

    assign done        = done_r;
    assign res_div     = res_div_r;
    assign res_mod     = res_mod_r;
    assign res_error   = res_error_r;
    assign res_timeout = res_timeout_r;
    assign res_owner   = res_owner_r;
    assign busy        = busy_r;
    assign dv_go       = dv_go_r;
    assign dv_a        = dv_a_r;
    assign dv_b        = dv_b_r;

endmodule

// File: tb/tb_divmod_arbiter.sv
// Self-checking bench for divmod_arbiter: a behavioural divider with
// programmable latency / stuck mode, a table of single-request vectors, hand
// sequences for rotation, timeout and reset, and a randomized multi-client run
// scored against a transaction-level model.

module tb_divmod_arbiter;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int TO = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   a_in, b_in;
    logic [N-1:0]     done;
    logic [W-1:0]     res_div, res_mod;
    logic             res_error, res_timeout;
    logic [2:0]       res_owner;
    logic             busy, dv_go;
    logic [W-1:0]     dv_a, dv_b;
    logic             dv_ready, dv_error;
    logic [W-1:0]     dv_div, dv_mod;

    divmod_arbiter #(.WIDTH_LOG(4), .NREQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .done(done), .res_div(res_div), .res_mod(res_mod),
        .res_error(res_error), .res_timeout(res_timeout), .res_owner(res_owner),
        .busy(busy), .dv_go(dv_go), .dv_a(dv_a), .dv_b(dv_b),
        .dv_ready(dv_ready), .dv_error(dv_error), .dv_div(dv_div), .dv_mod(dv_mod)
    );

    always #5 clk = ~clk;

    // Behavioural divider: starts on a rising go, answers b==0 at once,
    // otherwise after 'lat' cycles; 'stuck' freezes it busy.
    int           lat   = 1;
    bit           stuck = 1'b0;
    logic         m_ready, m_err, go_q;
    logic [W-1:0] m_div, m_mod, m_a, m_b;
    int           m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_ready <= 1'b1; m_err <= 1'b0; m_div <= '0; m_mod <= '0;
            m_cnt <= 0; go_q <= 1'b0; m_a <= '0; m_b <= '0;
        end else begin
            go_q <= dv_go;
            if (dv_go && !go_q) begin
                if (dv_b == '0) begin
                    m_ready <= 1'b1; m_err <= 1'b1; m_div <= '1; m_mod <= dv_a;
                end else begin
                    m_ready <= 1'b0; m_err <= 1'b0; m_cnt <= lat; m_a <= dv_a; m_b <= dv_b;
                end
            end else if (!m_ready && !stuck) begin
                if (m_cnt <= 1) begin
                    m_ready <= 1'b1; m_div <= m_a / m_b; m_mod <= m_a % m_b;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    assign dv_ready = m_ready;
    assign dv_error = m_err;
    assign dv_div   = m_div;
    assign dv_mod   = m_mod;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) ? {W{1'b1}} : a / b;
    endfunction

    function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) ? a : a % b;
    endfunction

    // Transaction-level model state
    typedef struct { logic [W-1:0] a; logic [W-1:0] b; } op_t;
    typedef struct { int owner; logic [W-1:0] a; logic [W-1:0] b; } exp_t;
    op_t  pend [N][$];
    exp_t exp_q[$];
    int   order_q[$];
    int   m_ptr  = 0;
    bit   m_busy = 1'b0;
    int   lat_lo = 1, lat_hi = 5;

    function automatic int model_pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (pend[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic set_client(input int cl, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[cl*W +: W] = a;
        b_in[cl*W +: W] = b;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"},    32'(done), 32'd0);
        check({tag, "_busy"},    32'(busy), 32'd0);
        check({tag, "_dv_go"},   32'(dv_go), 32'd0);
        check({tag, "_dv_a"},    32'(dv_a), 32'd0);
        check({tag, "_dv_b"},    32'(dv_b), 32'd0);
        check({tag, "_res_div"}, 32'(res_div), 32'd0);
        check({tag, "_res_mod"}, 32'(res_mod), 32'd0);
        check({tag, "_res_err"}, 32'(res_error), 32'd0);
        check({tag, "_res_to"},  32'(res_timeout), 32'd0);
        check({tag, "_owner"},   32'(res_owner), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; stuck = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ptr = 0; m_busy = 1'b0;
        exp_q.delete(); order_q.delete();
    endtask

    // One isolated request; operands are scrambled right after the grant.
    task automatic single(input string tag, input int cl, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int lt, input int exp_lat,
                          input logic [W-1:0] ediv, input logic [W-1:0] emod,
                          input logic eerr, input logic eto);
        int k, gos;
        logic [N-1:0] dn;
        @(negedge clk);
        set_client(cl, a, b); lat = lt; req[cl] = 1'b1;
        k = 0; gos = 0; dn = '0;
        while (k < 60 && dn == '0) begin
            @(negedge clk);
            k++;
            if (dv_go === 1'b1) gos++;
            dn = done;
            if (k == 1) set_client(cl, W'($urandom), W'($urandom));
        end
        req[cl] = 1'b0;
        check({tag, "_done_vec"}, 32'(dn), 32'd1 << cl);
        check({tag, "_latency"}, 32'(k), 32'(exp_lat));
        check({tag, "_div"}, 32'(res_div), 32'(ediv));
        check({tag, "_mod"}, 32'(res_mod), 32'(emod));
        check({tag, "_err"}, 32'(res_error), 32'(eerr));
        check({tag, "_to"}, 32'(res_timeout), 32'(eto));
        check({tag, "_owner"}, 32'(res_owner), 32'(cl));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        check({tag, "_go_cycles"}, 32'(gos), 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    // Clients take ops from pend[]; each raises req (with probability gate%)
    // when idle and drops it on the edge that samples its done.
    task automatic run_ops(input string tag, input int budget, input int gate);
        int c, own;
        logic [N-1:0] dn;
        exp_t e;
        c = 0;
        while (c < budget && !(all_empty() && exp_q.size() == 0 && !m_busy)) begin
            @(negedge clk);
            c++;
            dn = done;
            if (dn != '0) begin
                check({tag, "_onehot"}, 32'($onehot(dn)), 32'd1);
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL %s_unexpected_done: got done=%b, expected none", tag, dn);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_done_vec"}, 32'(dn), 32'd1 << e.owner);
                    check({tag, "_owner"}, 32'(res_owner), 32'(e.owner));
                    check({tag, "_div"}, 32'(res_div), 32'(ref_div(e.a, e.b)));
                    check({tag, "_mod"}, 32'(res_mod), 32'(ref_mod(e.a, e.b)));
                    check({tag, "_err"}, 32'(res_error), 32'(e.b == '0));
                    check({tag, "_to"}, 32'(res_timeout), 32'd0);
                    order_q.push_back(int'(res_owner));
                end
                for (int i = 0; i < N; i++) begin
                    if (dn[i]) begin
                        req[i] = 1'b0;
                        if (pend[i].size() > 0) void'(pend[i].pop_front());
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!dn[i] && !req[i]) begin
                    if (pend[i].size() > 0 && $urandom_range(0, 99) < gate) begin
                        set_client(i, pend[i][0].a, pend[i][0].b);
                        req[i] = 1'b1;
                    end else begin
                        set_client(i, W'($urandom), W'($urandom));
                    end
                end
            end
            if (!m_busy && req != '0 && m_ready) begin
                own   = model_pick(req);
                m_ptr = (own + 1) % N;
                exp_q.push_back('{own, pend[own][0].a, pend[own][0].b});
                lat    = $urandom_range(lat_lo, lat_hi);
                m_busy = 1'b1;
            end
            if (dn != '0) m_busy = 1'b0;
        end
        if (c >= budget) begin
            n_tests++; n_fail++;
            $display("FAIL %s_budget: got %0d ops outstanding after %0d cycles, expected 0",
                     tag, exp_q.size(), budget);
        end
    endtask

    task automatic check_order(input string tag, input int exp_ord[$]);
        check({tag, "_order_len"}, 32'(order_q.size()), 32'(exp_ord.size()));
        for (int i = 0; i < exp_ord.size() && i < order_q.size(); i++)
            check({tag, "_order"}, 32'(order_q[i]), 32'(exp_ord[i]));
    endtask

    typedef struct {
        int cl; logic [W-1:0] a; logic [W-1:0] b; int lt;
        logic [W-1:0] ediv; logic [W-1:0] emod; logic eerr;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int   busy_cnt, dcount, k;
        logic [N-1:0] dn;

        tbl[0] = '{2, 16'd100,   16'd7,     3, 16'd14,    16'd2,   1'b0};
        tbl[1] = '{0, 16'd5,     16'd0,     2, 16'hFFFF,  16'd5,   1'b1};
        tbl[2] = '{3, 16'd65535, 16'd1,     1, 16'd65535, 16'd0,   1'b0};
        tbl[3] = '{1, 16'd0,     16'd5,     2, 16'd0,     16'd0,   1'b0};
        tbl[4] = '{2, 16'd7,     16'd65535, 4, 16'd0,     16'd7,   1'b0};
        tbl[5] = '{1, 16'd1000,  16'd10,    5, 16'd100,   16'd0,   1'b0};
        tbl[6] = '{3, 16'd65535, 16'd256,   1, 16'd255,   16'd255, 1'b0};

        rst = 1'b1; req = '0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Single requests; latency counted from the grant edge.
        for (int i = 0; i < 7; i++)
            single($sformatf("vec%0d", i), tbl[i].cl, tbl[i].a, tbl[i].b, tbl[i].lt,
                   (tbl[i].b == '0) ? 3 : 3 + tbl[i].lt,
                   tbl[i].ediv, tbl[i].emod, tbl[i].eerr, 1'b0);

        // All four clients at once: served 0,1,2,3.
        do_reset();
        lat_lo = 1; lat_hi = 3;
        for (int i = 0; i < N; i++) pend[i].push_back('{W'(11 * (i + 3)), W'(i + 2)});
        run_ops("all4", 500, 100);
        check_order("all4", '{0, 1, 2, 3});

        // Client 1 re-requests at once while 3 waits: 1,3,1.
        do_reset();
        pend[1].push_back('{16'd77, 16'd5});
        pend[1].push_back('{16'd90, 16'd9});
        pend[3].push_back('{16'd64, 16'd6});
        run_ops("rereq", 500, 100);
        check_order("rereq", '{1, 3, 1});

        // Watchdog: divider never completes -> 11 WAIT cycles then error.
        do_reset();
        stuck = 1'b1;
        single("timeout", 0, 16'd50, 16'd3, 4, 13, 16'd0, 16'd0, 1'b1, 1'b1);
        // Divider still busy: a new request must not be granted yet.
        @(negedge clk);
        set_client(2, 16'd9, 16'd4); req[2] = 1'b1;
        busy_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("post_timeout_no_grant", 32'(busy_cnt), 32'd0);
        stuck = 1'b0; lat = 2;
        k = 0; dn = '0;
        while (k < 60 && dn == '0) begin
            @(negedge clk);
            k++;
            dn = done;
        end
        req[2] = 1'b0;
        check("post_timeout_done", 32'(dn), 32'b0100);
        check("post_timeout_div", 32'(res_div), 32'd2);
        check("post_timeout_mod", 32'(res_mod), 32'd1);
        check("post_timeout_err", 32'(res_error), 32'd0);
        check("post_timeout_to", 32'(res_timeout), 32'd0);

        // Reset while in WAIT.
        @(negedge clk);
        lat = 20; set_client(1, 16'd40, 16'd3); req[1] = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1; req = '0;
        @(negedge clk);
        check_idle_outputs("rst_mid");
        rst = 1'b0;
        m_ptr = 0; m_busy = 1'b0; exp_q.delete(); order_q.delete();
        dcount = 0;
        repeat (25) begin
            @(negedge clk);
            if (done != '0) dcount++;
        end
        check("rst_no_done", 32'(dcount), 32'd0);
        // Pointer back at 0: client 0 beats client 3.
        lat_lo = 2; lat_hi = 2;
        pend[0].push_back('{16'd9, 16'd3});
        pend[3].push_back('{16'd8, 16'd2});
        run_ops("after_rst", 200, 100);
        check_order("after_rst", '{0, 3});
        check("after_rst_last_div", 32'(res_div), 32'd4);

        // Randomized multi-client load.
        do_reset();
        lat_lo = 1; lat_hi = 5;
        for (int n = 0; n < 160; n++) begin
            int cl;
            logic [W-1:0] a, b;
            cl = $urandom_range(0, N - 1);
            a  = W'($urandom);
            if ($urandom_range(0, 7) == 0) b = '0;
            else if ($urandom_range(0, 1) == 1) b = W'($urandom_range(1, 15));
            else b = W'($urandom);
            pend[cl].push_back('{a, b});
        end
        run_ops("rand", 30000, 30);
        check("rand_ops_done", 32'(order_q.size()), 32'd160);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1);
    end

endmodule
